// File: rtl/regbank_wb_writer.sv
// regbank_wb_writer: queued write-back port for the 32-entry integer register bank.
// Requests drain in order through a one-hot decoder; x0 always reads zero.
module regbank_wb_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter int CNT_WIDTH   = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_InLow,
    input  logic                       WB_Valid_In,
    output logic                       WB_Ready_Out,
    input  logic [4:0]                 WB_Addr_InBUS,
    input  logic [DATA_WIDTH-1:0]      WB_Data_InBUS,
    input  logic                       WB_Flush_In,
    output logic [32*DATA_WIDTH-1:0]   REGBANK_Data_OutBUS,
    output logic [31:0]                REGBANK_Pending_OutBUS,
    output logic [CNT_WIDTH-1:0]       WB_Count_OutBUS
);
    localparam int PW = $clog2(QUEUE_DEPTH);

    logic [4:0]            q_addr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] regs [1:31];
    logic [PW-1:0]         head, tail;
    logic [CNT_WIDTH-1:0]  count;
    logic                  accept, drain;
    logic [31:1]           wr_sel;
    logic [31:0]           pend;

    assign WB_Ready_Out    = count != CNT_WIDTH'(QUEUE_DEPTH);
    assign accept          = WB_Valid_In && WB_Ready_Out && !WB_Flush_In;
    assign drain           = count != '0 && !WB_Flush_In;
    assign WB_Count_OutBUS = count;

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (WB_Flush_In) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= drain ? head + 1'b1 : head;
            tail  <= accept ? tail + 1'b1 : tail;
            count <= count + CNT_WIDTH'(accept) - CNT_WIDTH'(drain);
        end
    end

    // Slot contents need no reset: occupancy alone decides validity.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            q_addr[tail] <= WB_Addr_InBUS;
            q_data[tail] <= WB_Data_InBUS;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (CNT_WIDTH'(i) < count) pend[q_addr[head + PW'(i)]] = 1'b1;
        pend[0] = 1'b0;
    end
    assign REGBANK_Pending_OutBUS = pend;

    genvar g;
    generate
        for (g = 1; g < 32; g++) begin : g_dec
            assign wr_sel[g] = drain && q_addr[head] == 5'(g);
        end
        for (g = 0; g < 32; g++) begin : g_out
            if (g == 0) begin : g_zero
                assign REGBANK_Data_OutBUS[g*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin : g_reg
                assign REGBANK_Data_OutBUS[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
            end
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                if (wr_sel[i]) regs[i] <= q_data[head];
        end
    end
endmodule

// File: tb/tb_regbank_wb_writer.sv
// tb_regbank_wb_writer: directed plus randomized checks against a queue-based reference model.
module tb_regbank_wb_writer;
    localparam int DW = 32;
    localparam int QD = 2;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           valid = 1'b0;
    logic           flush = 1'b0;
    logic [4:0]     addr = '0;
    logic [DW-1:0]  data = '0;
    logic           ready;
    logic [32*DW-1:0] regbus;
    logic [31:0]    pend;
    logic [CW-1:0]  cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } req_t;
    req_t          q[$];
    logic [DW-1:0] m_regs [32];

    always #5 clk = ~clk;

    regbank_wb_writer #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD), .CNT_WIDTH(CW)) dut (
        .CLOCK_50(clk),
        .RESET_InLow(rst_n),
        .WB_Valid_In(valid),
        .WB_Ready_Out(ready),
        .WB_Addr_InBUS(addr),
        .WB_Data_InBUS(data),
        .WB_Flush_In(flush),
        .REGBANK_Data_OutBUS(regbus),
        .REGBANK_Pending_OutBUS(pend),
        .WB_Count_OutBUS(cnt)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].a] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic check_all(string tag);
        check({tag, " ready"}, 64'(ready), 64'(q.size() != QD));
        check({tag, " count"}, 64'(cnt), 64'(q.size()));
        check({tag, " pending"}, 64'(pend), 64'(model_pend()));
        for (int i = 0; i < 32; i++)
            check($sformatf("%s reg%0d", tag, i), 64'(regbus[i*DW +: DW]), 64'(m_regs[i]));
    endtask

    // One clock: drive, check pre-edge outputs, then advance the model across the edge.
    task automatic cycle(input bit v, input logic [4:0] a, input logic [DW-1:0] d,
                         input bit f, input string tag, output bit acc);
        bit dr;
        req_t r;
        valid = v; addr = a; data = d; flush = f;
        @(negedge clk);
        check_all(tag);
        acc = v && (q.size() != QD) && !f;
        dr  = (q.size() != 0) && !f;
        if (f) q.delete();
        else begin
            if (dr) begin
                r = q.pop_front();
                if (r.a != 0) m_regs[r.a] = r.d;
            end
            if (acc) q.push_back('{a: a, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    bit            acc;
    bit            hold;
    bit            v;
    bit            f;
    logic [4:0]    ra;
    logic [DW-1:0] rd;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        cycle(1, 5'd5, 32'hDEADBEEF, 0, "wr5", acc);
        cycle(0, 5'd0, 32'h0, 0, "wr5_pend", acc);
        cycle(0, 5'd0, 32'h0, 0, "wr5_done", acc);

        cycle(1, 5'd0, 32'hFFFFFFFF, 0, "x0", acc);
        cycle(0, 5'd0, 32'h0, 0, "x0_q", acc);
        cycle(0, 5'd0, 32'h0, 0, "x0_done", acc);

        cycle(1, 5'd1, 32'h11, 0, "b2b1", acc);
        cycle(1, 5'd2, 32'h22, 0, "b2b2", acc);
        cycle(1, 5'd3, 32'h33, 0, "b2b3", acc);
        cycle(0, 5'd0, 32'h0, 0, "b2b_d1", acc);
        cycle(0, 5'd0, 32'h0, 0, "b2b_d2", acc);

        cycle(1, 5'd7, 32'hA, 0, "haz1", acc);
        cycle(1, 5'd7, 32'hB, 0, "haz2", acc);
        cycle(0, 5'd0, 32'h0, 0, "haz_d1", acc);
        cycle(0, 5'd0, 32'h0, 0, "haz_d2", acc);

        cycle(1, 5'd9, 32'h99, 0, "fl9", acc);
        cycle(1, 5'd10, 32'h1010, 0, "fl10", acc);
        cycle(1, 5'd4, 32'h44, 1, "flush", acc);
        check("flush_accept", 64'(acc), 64'(0));
        cycle(0, 5'd0, 32'h0, 0, "post_flush", acc);

        hold = 0;
        ra = '0;
        rd = '0;
        for (int n = 0; n < 300; n++) begin
            if (!hold) begin
                ra = 5'($urandom);
                rd = $urandom;
            end
            v = hold ? 1'b1 : 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 9) == 0);
            cycle(v, ra, rd, f, "rnd", acc);
            hold = v && !acc;
        end

        cycle(1, 5'd12, 32'h5, 0, "pre_rst", acc);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_hold");
        rst_n = 1'b1;
        cycle(0, 5'd0, 32'h0, 0, "post_rst1", acc);
        cycle(0, 5'd0, 32'h0, 0, "post_rst2", acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
